// File: rtl/fetch_ram_pp_banked_if.sv
// Fetch RAM bus: narrow write side, wide read side, page handshake.
// master drives strobes/addresses/data, slave returns ready/valid/rd_data.
interface fetch_ram_pp_banked_if #(
  parameter int WORD_W = 64,
  parameter int NBANK  = 2,
  parameter int AW     = 6,
  parameter int BW     = 1
);
  logic                    wr_en_i;
  logic [WORD_W-1:0]       wr_data_i;
  logic [AW-1:0]           wr_addr_i;
  logic [BW-1:0]           wr_bank_i;
  logic                    wr_last_i;
  logic                    wr_ready_o;
  logic                    rd_valid_o;
  logic                    rd_en_i;
  logic [AW-1:0]           rd_addr_i;
  logic [NBANK*WORD_W-1:0] rd_data_o;
  logic                    rd_release_i;

  modport master (
    output wr_en_i, wr_data_i, wr_addr_i,
    output wr_bank_i, wr_last_i,
    output rd_en_i, rd_addr_i, rd_release_i,
    input  wr_ready_o, rd_valid_o, rd_data_o
  );

  modport slave (
    input  wr_en_i, wr_data_i, wr_addr_i,
    input  wr_bank_i, wr_last_i,
    input  rd_en_i, rd_addr_i, rd_release_i,
    output wr_ready_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/fetch_ram_pp_banked.sv
// Ping-pong banked fetch buffer: NBANK x WORD_W write, NBANK*WORD_W read.
// Ports: clk, rst (sync, active-high), bus (slave modport of _if).
module fetch_ram_pp_banked #(
  parameter int WORD_W  = 64,
  parameter int NBANK   = 2,
  parameter int DEPTH   = 48,
  parameter int WR_MODE = 0,
  parameter int AW      = 6,
  parameter int BW      = 1
) (
  input  logic clk,
  input  logic rst,
  fetch_ram_pp_banked_if.slave bus
);

  localparam int IW = $clog2(2 * DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WORD_W-1:0] mem [NBANK][2*DEPTH];

  logic [1:0]    valid, valid_nxt;
  logic          wr_page, rd_page;
  logic [BW-1:0] wcnt_b;
  logic [AW-1:0] wcnt_a;

  logic          wr_acc, rd_acc, rel_acc;
  logic          wr_we, wr_close, seq_last;
  logic          rd_in;
  logic [BW-1:0] w_bank;
  logic [AW-1:0] w_addr;
  logic [IW-1:0] w_idx, r_idx;

  // Mode-0 ignores the explicit address fields.
  logic unused_mode0;
  assign unused_mode0 = ^{bus.wr_addr_i, bus.wr_bank_i, bus.wr_last_i};

  // Page bit selects the upper half of each bank.
  function automatic logic [IW-1:0] idx(
    input logic          pg,
    input logic [AW-1:0] a
  );
    return pg ? IW'(a) + IW'(DEPTH) : IW'(a);
  endfunction

  assign bus.wr_ready_o = ~valid[wr_page];
  assign bus.rd_valid_o = valid[rd_page];

  always_comb begin
    wr_acc   = bus.wr_en_i & bus.wr_ready_o;
    rd_acc   = bus.rd_en_i & bus.rd_valid_o;
    rel_acc  = bus.rd_release_i & bus.rd_valid_o;
    seq_last = (wcnt_b == BW'(NBANK - 1)) &&
               (wcnt_a == AW'(DEPTH - 1));
    w_bank   = wcnt_b;
    w_addr   = wcnt_a;
    wr_we    = wr_acc;
    wr_close = wr_acc & seq_last;
    if (WR_MODE != 0) begin
      w_bank   = bus.wr_bank_i;
      w_addr   = bus.wr_addr_i;
      // Out-of-range writes vanish but may still close the page.
      wr_we    = wr_acc & ({1'b0, bus.wr_addr_i} < DEPTH_W);
      wr_close = wr_acc & bus.wr_last_i;
    end
    w_idx = idx(wr_page, w_addr);
    r_idx = idx(rd_page, bus.rd_addr_i);
    rd_in = {1'b0, bus.rd_addr_i} < DEPTH_W;
    // Close and release always hit different pages.
    valid_nxt = valid;
    if (wr_close) valid_nxt[wr_page] = 1'b1;
    if (rel_acc)  valid_nxt[rd_page] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_we) mem[w_bank][w_idx] <= bus.wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid         <= '0;
      wr_page       <= 1'b0;
      rd_page       <= 1'b0;
      wcnt_b        <= '0;
      wcnt_a        <= '0;
      bus.rd_data_o <= '0;
    end else begin
      valid <= valid_nxt;
      if (wr_close) wr_page <= ~wr_page;
      if (rel_acc)  rd_page <= ~rd_page;
      if (WR_MODE == 0 && wr_acc) begin
        if (seq_last) begin
          wcnt_b <= '0;
          wcnt_a <= '0;
        end else if (wcnt_b == BW'(NBANK - 1)) begin
          wcnt_b <= '0;
          wcnt_a <= wcnt_a + 1'b1;
        end else begin
          wcnt_b <= wcnt_b + 1'b1;
        end
      end
      if (rd_acc) begin
        for (int k = 0; k < NBANK; k++) begin
          bus.rd_data_o[k*WORD_W +: WORD_W] <=
            rd_in ? mem[k][r_idx] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_ram_pp_banked.sv
// Directed bench for fetch_ram_pp_banked.
// Instance a: defaults (seq mode, 2 banks); b: explicit mode, 4 banks.
module tb_fetch_ram_pp_banked;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_ram_pp_banked_if #(
    .WORD_W(64), .NBANK(2), .AW(6), .BW(1)
  ) a ();

  fetch_ram_pp_banked_if #(
    .WORD_W(64), .NBANK(4), .AW(6), .BW(2)
  ) b ();

  fetch_ram_pp_banked #(
    .WORD_W(64), .NBANK(2), .DEPTH(48),
    .WR_MODE(0), .AW(6), .BW(1)
  ) u_a (
    .clk(clk), .rst(rst), .bus(a.slave)
  );

  fetch_ram_pp_banked #(
    .WORD_W(64), .NBANK(4), .DEPTH(48),
    .WR_MODE(1), .AW(6), .BW(2)
  ) u_b (
    .clk(clk), .rst(rst), .bus(b.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      a.wr_en_i   = 1'b1;
      a.wr_data_i = 64'(base + i);
      tick();
    end
    a.wr_en_i = 1'b0;
  endtask

  task automatic rd_a(input int ad);
    a.rd_en_i   = 1'b1;
    a.rd_addr_i = 6'(ad);
    tick();
    a.rd_en_i   = 1'b0;
  endtask

  task automatic rd_b(input int ad);
    b.rd_en_i   = 1'b1;
    b.rd_addr_i = 6'(ad);
    tick();
    b.rd_en_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if (a.wr_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_wr_ready got %b want 1", a.wr_ready_o);
    end
    n_chk++;
    if (a.rd_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rd_valid got %b want 0", a.rd_valid_o);
    end
    n_chk++;
    if (a.rd_data_o !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_rd_data got %h want 0", a.rd_data_o);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 96; i++) begin
      a.wr_en_i   = 1'b1;
      a.wr_data_i = 64'(i);
      tick();
      if (i < 95) begin
        n_chk++;
        if (a.rd_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_rd_valid w%0d got %b want 0",
                   i, a.rd_valid_o);
        end
      end
    end
    a.wr_en_i = 1'b0;
    n_chk++;
    if (a.rd_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_done_rd_valid got %b want 1", a.rd_valid_o);
    end
    n_chk++;
    if (a.wr_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_done_wr_ready got %b want 1", a.wr_ready_o);
    end
    rd_a(5);
    n_chk++;
    if (a.rd_data_o !== {64'd11, 64'd10}) begin
      n_fail++;
      $display("FAIL fill_rd5 got %h want %h",
               a.rd_data_o, {64'd11, 64'd10});
    end
  endtask

  task automatic test_back_to_back();
    fill(96, 100);
    n_chk++;
    if (a.wr_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full_wr_ready got %b want 0", a.wr_ready_o);
    end
    a.wr_en_i   = 1'b1;
    a.wr_data_i = 64'd999;
    tick();
    a.wr_en_i = 1'b0;
    n_chk++;
    if (a.wr_ready_o !== 1'b0 || a.rd_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drop rdy/vld got %b%b want 01",
               a.wr_ready_o, a.rd_valid_o);
    end
    a.rd_release_i = 1'b1;
    tick();
    a.rd_release_i = 1'b0;
    n_chk++;
    if (a.wr_ready_o !== 1'b1 || a.rd_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_release rdy/vld got %b%b want 11",
               a.wr_ready_o, a.rd_valid_o);
    end
    rd_a(5);
    n_chk++;
    if (a.rd_data_o !== {64'd111, 64'd110}) begin
      n_fail++;
      $display("FAIL b2b_pg1_rd5 got %h want %h",
               a.rd_data_o, {64'd111, 64'd110});
    end
    rd_a(0);
    n_chk++;
    if (a.rd_data_o !== {64'd101, 64'd100}) begin
      n_fail++;
      $display("FAIL b2b_pg1_rd0 got %h want %h",
               a.rd_data_o, {64'd101, 64'd100});
    end
  endtask

  task automatic test_close_release();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fill(96, 0);
    fill(95, 200);
    a.wr_en_i      = 1'b1;
    a.wr_data_i    = 64'd295;
    a.rd_release_i = 1'b1;
    tick();
    a.wr_en_i      = 1'b0;
    a.rd_release_i = 1'b0;
    n_chk++;
    if (a.rd_valid_o !== 1'b1 || a.wr_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cr_same_cycle vld/rdy got %b%b want 11",
               a.rd_valid_o, a.wr_ready_o);
    end
    rd_a(47);
    n_chk++;
    if (a.rd_data_o !== {64'd295, 64'd294}) begin
      n_fail++;
      $display("FAIL cr_pg1_rd47 got %h want %h",
               a.rd_data_o, {64'd295, 64'd294});
    end
    a.rd_release_i = 1'b1;
    tick();
    a.rd_release_i = 1'b0;
    n_chk++;
    if (a.rd_valid_o !== 1'b0 || a.wr_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cr_empty vld/rdy got %b%b want 01",
               a.rd_valid_o, a.wr_ready_o);
    end
  endtask

  task automatic test_explicit();
    b.wr_en_i   = 1'b1;
    b.wr_bank_i = 2'd3;
    b.wr_addr_i = 6'd7;
    b.wr_data_i = 64'hAA;
    b.wr_last_i = 1'b0;
    tick();
    n_chk++;
    if (b.rd_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL exp_early_vld got %b want 0", b.rd_valid_o);
    end
    b.wr_bank_i = 2'd0;
    b.wr_addr_i = 6'd0;
    b.wr_data_i = 64'h55;
    b.wr_last_i = 1'b1;
    tick();
    b.wr_en_i   = 1'b0;
    b.wr_last_i = 1'b0;
    n_chk++;
    if (b.rd_valid_o !== 1'b1 || b.wr_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL exp_close vld/rdy got %b%b want 11",
               b.rd_valid_o, b.wr_ready_o);
    end
    rd_b(7);
    n_chk++;
    if (b.rd_data_o[255:192] !== 64'hAA) begin
      n_fail++;
      $display("FAIL exp_rd7_b3 got %h want aa",
               b.rd_data_o[255:192]);
    end
    rd_b(0);
    n_chk++;
    if (b.rd_data_o[63:0] !== 64'h55) begin
      n_fail++;
      $display("FAIL exp_rd0_b0 got %h want 55", b.rd_data_o[63:0]);
    end
    rd_b(60);
    n_chk++;
    if (b.rd_data_o !== 256'd0) begin
      n_fail++;
      $display("FAIL exp_rd60 got %h want 0", b.rd_data_o);
    end
    b.wr_en_i   = 1'b1;
    b.wr_bank_i = 2'd1;
    b.wr_addr_i = 6'd50;
    b.wr_data_i = 64'h77;
    b.wr_last_i = 1'b1;
    tick();
    b.wr_en_i   = 1'b0;
    b.wr_last_i = 1'b0;
    n_chk++;
    if (b.wr_ready_o !== 1'b0 || b.rd_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL exp_oob_close rdy/vld got %b%b want 01",
               b.wr_ready_o, b.rd_valid_o);
    end
  endtask

  task automatic test_mid_reset();
    fill(30, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (a.wr_ready_o !== 1'b1 || a.rd_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_flags rdy/vld got %b%b want 10",
               a.wr_ready_o, a.rd_valid_o);
    end
    n_chk++;
    if (a.rd_data_o !== 128'd0) begin
      n_fail++;
      $display("FAIL mr_rd_data got %h want 0", a.rd_data_o);
    end
    fill(95, 300);
    n_chk++;
    if (a.rd_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_95_vld got %b want 0", a.rd_valid_o);
    end
    fill(1, 395);
    n_chk++;
    if (a.rd_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_96_vld got %b want 1", a.rd_valid_o);
    end
  endtask

  task automatic test_stream_read();
    int adr [6] = '{0, 3, 7, 47, 50, 1};
    logic [127:0] exp;
    a.rd_en_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a.rd_addr_i = 6'(adr[i]);
      tick();
      if (adr[i] < 48)
        exp = {64'(301 + 2 * adr[i]), 64'(300 + 2 * adr[i])};
      else
        exp = '0;
      n_chk++;
      if (a.rd_data_o !== exp) begin
        n_fail++;
        $display("FAIL stream_rd%0d got %h want %h",
                 adr[i], a.rd_data_o, exp);
      end
    end
    a.rd_en_i   = 1'b0;
    a.rd_addr_i = 6'd9;
    tick();
    n_chk++;
    if (a.rd_data_o !== {64'd303, 64'd302}) begin
      n_fail++;
      $display("FAIL stream_hold got %h want %h",
               a.rd_data_o, {64'd303, 64'd302});
    end
    a.rd_release_i = 1'b1;
    tick();
    a.rd_release_i = 1'b0;
    rd_a(9);
    n_chk++;
    if (a.rd_valid_o !== 1'b0 ||
        a.rd_data_o !== {64'd303, 64'd302}) begin
      n_fail++;
      $display("FAIL stream_novalid vld %b data %h want 0 %h",
               a.rd_valid_o, a.rd_data_o, {64'd303, 64'd302});
    end
  endtask

  initial begin
    a.wr_en_i = 1'b0; a.wr_data_i = '0; a.wr_addr_i = '0;
    a.wr_bank_i = '0; a.wr_last_i = 1'b0; a.rd_en_i = 1'b0;
    a.rd_addr_i = '0; a.rd_release_i = 1'b0;
    b.wr_en_i = 1'b0; b.wr_data_i = '0; b.wr_addr_i = '0;
    b.wr_bank_i = '0; b.wr_last_i = 1'b0; b.rd_en_i = 1'b0;
    b.rd_addr_i = '0; b.rd_release_i = 1'b0;
    test_reset();
    test_explicit();
    test_fill();
    test_back_to_back();
    test_close_release();
    test_mid_reset();
    test_stream_read();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
